// File: rtl/ref_mem_ctrl.sv
// Reference-memory sequencer: a LOAD phase that writes incoming search-window
// rows into the 32-bank memory, followed by a READ phase that issues the read
// schedule in either 8-row mode or 1-row mode.
module ref_mem_ctrl #(
    parameter int LOAD_ROWS = 64,
    parameter int RD_ADDRS  = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic         ref_in_valid,
    input  logic [255:0] ref_in_data,
    output logic         ref_in_ready,
    output logic [255:0] ref_input,
    output logic [31:0]  Bank_sel,
    output logic [223:0] write_address_all,
    output logic [6:0]   rd_address,
    output logic         rd8R_en,
    output logic [3:0]   rdR_sel,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic           r_mode;
    logic [11:0]    r_row;
    logic [6:0]     r_a;
    logic [2:0]     r_s;
    logic           r_rd_all;

    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic [255:0]   r_ref_input;
    logic [31:0]    r_bank_sel;
    logic [223:0]   r_waddr_all;
    logic [6:0]     r_rd_address;
    logic           r_rd8r_en;
    logic [3:0]     r_rdr_sel;

    logic           w_accept;
    logic           w_last_row;
    logic           w_last_rd;
    logic           w_ready_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;

    // Beat acceptance only happens in LOAD, where ready is held high.
    assign w_accept   = (r_state == ST_LOAD) && ref_in_valid;
    assign w_last_row = (r_row == 12'(LOAD_ROWS - 1));
    // In 1-row mode the final address is only complete after its 8th select.
    assign w_last_rd  = (r_a == 7'(RD_ADDRS - 1)) && (!r_mode || (r_s == 3'd7));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last_row) begin
                    w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_READ: begin
                // One trailing READ cycle lets the last registered read show.
                if (r_rd_all) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the next state so their registers align with the state.
    always_comb begin
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_next_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ST_LOAD: begin
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            ST_READ: begin
                w_busy_nxt = 1'b1;
            end
            ST_DONE: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Write path: register each accepted row with its bank one-hot and bank address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= 12'd0;
            r_ref_input <= 256'd0;
            r_bank_sel  <= 32'd0;
            r_waddr_all <= 224'd0;
        end else if (w_accept) begin
            r_ref_input <= ref_in_data;
            r_bank_sel  <= 32'd1 << r_row[4:0];
            r_waddr_all <= {32{r_row[11:5]}};
            r_row       <= w_last_row ? 12'd0 : (r_row + 12'd1);
        end else begin
            // Data and address hold; only the enables drop.
            r_bank_sel  <= 32'd0;
        end
    end

    // Read schedule: mode latch, address/select counters and registered read controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= 1'b0;
            r_a          <= 7'd0;
            r_s          <= 3'd0;
            r_rd_all     <= 1'b0;
            r_rd_address <= 7'd0;
            r_rd8r_en    <= 1'b0;
            r_rdr_sel    <= 4'd0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_mode <= mode;
            end
            if ((r_state == ST_READ) && !r_rd_all) begin
                r_rd_address <= r_a;
                r_rd8r_en    <= !r_mode;
                r_rdr_sel    <= r_mode ? {1'b0, r_s} : 4'd0;
                if (w_last_rd) begin
                    r_rd_all <= 1'b1;
                end else if (!r_mode || (r_s == 3'd7)) begin
                    r_a <= r_a + 7'd1;
                    r_s <= 3'd0;
                end else begin
                    r_s <= r_s + 3'd1;
                end
            end else begin
                r_rd_address <= 7'd0;
                r_rd8r_en    <= 1'b0;
                r_rdr_sel    <= 4'd0;
                // Counters are cleared while loading so each read pass starts at zero.
                if (r_state == ST_LOAD) begin
                    r_a      <= 7'd0;
                    r_s      <= 3'd0;
                    r_rd_all <= 1'b0;
                end
            end
        end
    end

    assign ref_in_ready      = r_ready;
    assign ref_input         = r_ref_input;
    assign Bank_sel          = r_bank_sel;
    assign write_address_all = r_waddr_all;
    assign rd_address        = r_rd_address;
    assign rd8R_en           = r_rd8r_en;
    assign rdR_sel           = r_rdr_sel;
    assign busy              = r_busy;
    assign done              = r_done;

endmodule
